// File: rtl/logic_gate_unit.sv
// Pipelined WIDTH-bit logic unit: eight bitwise ops with an optional accumulator
// operand, one register stage behind valid/ready, reduction flags and a saturating beat count.
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_rand,
    output logic             y_ror,
    output logic             y_rxor,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_rand_q, y_rand_d;
    logic             y_ror_q, y_ror_d;
    logic             y_rxor_q, y_rxor_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH-1:0] s_opnd;
    logic [WIDTH-1:0] op_res;

    // The output register may be refilled in the same cycle it is drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign s_opnd = acc_mode ? acc_q : b;

    always_comb begin
        // NOTE: every combinational output gets a value on every path; a missing default infers a latch.
        op_res = a;
        case (op)
            OP_AND:  op_res = a & s_opnd;
            OP_OR:   op_res = a | s_opnd;
            OP_XOR:  op_res = a ^ s_opnd;
            OP_NAND: op_res = ~(a & s_opnd);
            OP_NOR:  op_res = ~(a | s_opnd);
            OP_XNOR: op_res = ~(a ^ s_opnd);
            OP_NOTA: op_res = ~a;
            OP_PASS: op_res = a;
            default: op_res = a;
        endcase
        if (acc_mode && acc_clr) begin
            op_res = a;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_rand_d    = y_rand_q;
        y_ror_d     = y_ror_q;
        y_rxor_d    = y_rxor_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            y_d         = op_res;
            y_rand_d    = &op_res;
            y_ror_d     = |op_res;
            y_rxor_d    = ^op_res;
            if (acc_mode) begin
                acc_d = op_res;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the accumulator is a single register, not an array, so resetting it costs nothing and is required.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_rand_q    <= 1'b0;
            y_ror_q     <= 1'b0;
            y_rxor_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_rand_q    <= y_rand_d;
            y_ror_q     <= y_ror_d;
            y_rxor_q    <= y_rxor_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_rand    = y_rand_q;
    assign y_ror     = y_ror_q;
    assign y_rxor    = y_rxor_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed test-plan steps followed by
// randomized traffic, all compared against a truth-table reference model.
module tb_logic_gate_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         acc_mode = 1'b0;
    logic         acc_clr = 1'b0;

    logic         in_ready, out_valid, y_rand, y_ror, y_rxor;
    logic [W-1:0] y;
    logic [15:0]  beat_cnt;

    logic         s_in_ready, s_out_valid, s_y_rand, s_y_ror, s_y_rxor;
    logic [W-1:0] s_y;
    logic [2:0]   s_beat_cnt;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic         m_valid;
    logic [W-1:0] m_y;
    logic [W-1:0] m_acc;
    int           m_cnt;

    always #5 clk = ~clk;

    logic_gate_unit #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .y_rand(y_rand), .y_ror(y_ror), .y_rxor(y_rxor), .beat_cnt(beat_cnt)
    );

    // Same stimulus into a 3-bit counter variant to exercise saturation.
    logic_gate_unit #(.WIDTH(W), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(s_out_valid), .out_ready(out_ready), .y(s_y),
        .y_rand(s_y_rand), .y_ror(s_y_ror), .y_rxor(s_y_rxor), .beat_cnt(s_beat_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each op as a truth table indexed by {a_bit, s_bit}.
    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] s);
        logic [3:0]   tt;
        logic [W-1:0] r;
        case (o)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b0111;
            3'd4: tt = 4'b0001;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        r = '0;
        for (int i = 0; i < W; i++) r[i] = tt[{x[i], s[i]}];
        return r;
    endfunction

    function automatic int popcount(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = '0;
        m_acc   = '0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        int ones;
        ones = popcount(m_y);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".y"}, 32'(y), 32'(m_y));
        check({tag, ".rand"}, 32'(y_rand), 32'(ones == W));
        check({tag, ".ror"}, 32'(y_ror), 32'(ones != 0));
        check({tag, ".rxor"}, 32'(y_rxor), 32'(ones % 2));
        check({tag, ".cnt"}, 32'(beat_cnt), 32'(m_cnt));
        check({tag, ".cnt_sat"}, 32'(s_beat_cnt), 32'((m_cnt > 7) ? 7 : m_cnt));
    endtask

    // One clock: check in_ready, take the edge, advance the model, check outputs.
    task automatic cycle(input string tag);
        logic exp_ready, acc;
        logic [W-1:0] res;
        #1;
        exp_ready = !m_valid || out_ready;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        acc = in_valid && exp_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            if (acc_mode && acc_clr) res = a;
            else res = ref_op(op, a, acc_mode ? m_acc : b);
            m_y     = res;
            m_valid = 1'b1;
            if (acc_mode) m_acc = res;
            m_cnt++;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2:0] o, input logic am, input logic ac);
        in_valid = v; a = av; b = bv; op = o; acc_mode = am; acc_clr = ac;
    endtask

    logic [W-1:0] basic_exp [8];

    initial begin
        basic_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};
        model_reset();

        // Reset state
        #12;
        check_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic ops, continuous stream
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b0, 1'b0);
            cycle("basic");
            check("basic.const", 32'(y), 32'(basic_exp[i]));
        end
        check("basic.cnt8", 32'(beat_cnt), 32'd8);
        check("sat.cnt7", 32'(s_beat_cnt), 32'd7);

        // Reductions
        drive(1'b1, 8'hFF, 8'hFF, 3'b000, 1'b0, 1'b0);
        cycle("red1");
        check("red1.flags", {29'd0, y_rand, y_ror, y_rxor}, 32'b110);
        drive(1'b1, 8'h01, 8'hFF, 3'b111, 1'b0, 1'b0);
        cycle("red2");
        check("red2.flags", {29'd0, y_rand, y_ror, y_rxor}, 32'b011);

        // Backpressure: hold a new beat while the consumer stalls
        drive(1'b1, 8'hF0, 8'hCC, 3'b000, 1'b0, 1'b0);
        cycle("bp_first");
        out_ready = 1'b0;
        drive(1'b1, 8'hF0, 8'hCC, 3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle("bp_stall");
            check("bp_stall.y", 32'(y), 32'h00C0);
        end
        out_ready = 1'b1;
        cycle("bp_release");
        check("bp_release.y", 32'(y), 32'h00FC);
        in_valid = 1'b0;
        cycle("bp_drain");
        check("bp_drain.y_hold", 32'(y), 32'h00FC);

        // Accumulate
        drive(1'b1, 8'hFF, 8'h00, 3'b101, 1'b1, 1'b1);
        cycle("acc_seed");
        check("acc_seed.y", 32'(y), 32'h00FF);
        drive(1'b1, 8'hF3, 8'h00, 3'b000, 1'b1, 1'b0);
        cycle("acc_and1");
        check("acc_and1.y", 32'(y), 32'h00F3);
        drive(1'b1, 8'h3F, 8'h00, 3'b000, 1'b1, 1'b0);
        cycle("acc_and2");
        check("acc_and2.y", 32'(y), 32'h0033);
        drive(1'b1, 8'h33, 8'h00, 3'b010, 1'b1, 1'b0);
        cycle("acc_xor");
        check("acc_xor.y", 32'(y), 32'h0000);
        check("acc_xor.ror", 32'(y_ror), 32'd0);

        // acc_clr without accept must not touch the accumulator
        drive(1'b0, 8'hAA, 8'h00, 3'b000, 1'b1, 1'b1);
        cycle("acc_idle");

        // Async reset in the middle of a stall
        drive(1'b1, 8'h81, 8'h0F, 3'b001, 1'b0, 1'b0);
        cycle("pre_rst");
        out_ready = 1'b0;
        cycle("stall_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h5A, 8'h00, 3'b001, 1'b1, 1'b0);
        cycle("post_rst");
        check("post_rst.y", 32'(y), 32'h005A);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                  3'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0));
            out_ready = 1'($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Parametrised, pipelined successor to the single-bit two-input gate.
- Applies one of eight bitwise logic ops to WIDTH-bit operands and registers the result behind a valid/ready handshake.
- Adds an accumulate mode, which folds a stream of operands into a running result, and reduction flags on the result.
- Sits as a leaf datapath element between a producer and a consumer that both use valid/ready.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of accepted-beat counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a beat on a/b/op/acc_mode/acc_clr
in_ready  output  1  unit can accept a beat this cycle
a  input  WIDTH  first operand
b  input  WIDTH  second operand (ignored in accumulate mode)
op  input  3  operation select
acc_mode  input  1  1 = second operand is internal accumulator
acc_clr  input  1  with acc_mode: seed accumulator with a
out_valid  output  1  y and flags hold a valid result
out_ready  input  1  consumer takes result this cycle
y  output  WIDTH  registered result
y_rand  output  1  AND-reduction of y
y_ror  output  1  OR-reduction of y
y_rxor  output  1  XOR-reduction of y
beat_cnt  output  CNT_W  number of accepted beats, saturating

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (asynchronous on rst_n low; takes effect immediately, including mid-transfer):
  - out_valid=0, y=0, y_rand=0, y_ror=0, y_rxor=0, beat_cnt=0, accumulator=0.
  - Any held, unconsumed result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - Accept occurs when in_valid && in_ready at a clk edge.
  - Output transfer occurs when out_valid && out_ready.
- Latency and throughput:
  - A beat accepted at edge N is presented on y/out_valid after edge N.
  - Full throughput is 1 beat/cycle while out_ready=1.
- Simultaneous transfer: accept and output transfer in the same cycle replace the result; out_valid stays 1.
- Output transfer with no accept: out_valid goes to 0 next edge; y holds its last value.
- Stall: while out_valid=1 && out_ready=0, y, the flags and out_valid are stable and in_ready=0.
- op encoding, where s is the second operand:
  - 000 a&s; 001 a|s; 010 a^s.
  - 011 ~(a&s); 100 ~(a|s); 101 ~(a^s).
  - 110 ~a; 111 a.
- Second operand s:
  - s = b when acc_mode=0.
  - s = accumulator when acc_mode=1.
- Accumulator updates only on accept with acc_mode=1:
  - acc_clr=1: accumulator <= a and y <= a; op is ignored for that beat.
  - acc_clr=0: y <= op(a, accumulator) and accumulator <= the same value.
- Accumulator does not change on beats with acc_mode=0, or when acc_clr is asserted without an accept.
- y_rand, y_ror and y_rxor are registered together with y, so they always match the presented y.
- beat_cnt:
  - Increments by 1 per accept.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Inputs are sampled only on accept; values outside accept cycles have no effect.

Test Plan:
- Basic ops (WIDTH=8, out_ready=1, acc_mode=0): a=0xF0, b=0xCC, op=000..111 on consecutive cycles -> y one cycle later = 0xC0, 0xFC, 0x3C, 0x3F, 0x03, 0xC3, 0x0F, 0xF0; out_valid continuous; beat_cnt=8.
- Reductions: a=0xFF, b=0xFF, op=000 -> y=0xFF, y_rand=1, y_ror=1, y_rxor=0. Then a=0x01, op=111 -> y_rand=0, y_ror=1, y_rxor=1.
- Backpressure: out_ready=0 after the first result 0xC0, in_valid held with a new beat -> in_ready=0, y stays 0xC0 for 5 cycles. Raise out_ready -> 0xC0 consumed and the new beat accepted in the same cycle; no beat lost or duplicated.
- Accumulate: acc_mode=1 beats are (acc_clr=1, a=0xFF), then op=000 with a=0xF3, then a=0x3F -> y = 0xFF, 0xF3, 0x33. Then op=010 with a=0x33 -> y=0x00, y_ror=0.
- Counter saturation (CNT_W=3): 10 accepted beats -> beat_cnt reads 1..7, then holds 7.
- Async reset mid-stall: out_valid=1, out_ready=0, rst_n pulsed low between edges -> out_valid, y, flags and beat_cnt read 0 immediately. A following op=001 acc_mode=1 acc_clr=0 beat with a=0x5A -> y=0x5A (accumulator was reset to 0).
